// File: rtl/pipes_pkg.sv
// Shared types and constants for the divide front-end: op encoding, FSM states, signed MIN values.
// Op encoding puts W-ness, REM-ness and unsignedness on separate bits so decode is plain bit picks.
package pipes;

    typedef enum logic [2:0] {
        DIV   = 3'd0,
        DIVU  = 3'd1,
        REM   = 3'd2,
        REMU  = 3'd3,
        DIVW  = 3'd4,
        DIVUW = 3'd5,
        REMW  = 3'd6,
        REMUW = 3'd7
    } div_op_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        WAIT    = 3'd2,
        CAPTURE = 3'd3,
        RESP    = 3'd4,
        DRAIN   = 3'd5
    } div_state_t;

    localparam logic [63:0] SMIN64 = 64'h8000_0000_0000_0000;
    localparam logic [31:0] SMIN32 = 32'h8000_0000;

    function automatic logic op_is_w(input logic [2:0] op);
        return op[2];
    endfunction

    function automatic logic op_is_rem(input logic [2:0] op);
        return op[1];
    endfunction

    function automatic logic op_is_unsigned(input logic [2:0] op);
        return op[0];
    endfunction

endpackage

// File: rtl/div_sign_fix.sv
// Combinational sign fix-up of the unsigned core result, with divide-by-zero / overflow forcing.
// Zero latency; no flow control. W ops sign-extend bit 31 of the selected quotient or remainder.
module div_sign_fix
    import pipes::*;
#(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] uq_i,
    input  logic [WIDTH-1:0] ur_i,
    input  logic             neg_q_i,
    input  logic             neg_r_i,
    input  logic [2:0]       op_i,
    input  logic             dz_i,
    input  logic             ovf_i,
    input  logic [WIDTH-1:0] a_i,
    output logic [WIDTH-1:0] result_o
);

    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] sel;

    always_comb begin
        q = neg_q_i ? -uq_i : uq_i;
        r = neg_r_i ? -ur_i : ur_i;
        if (dz_i) begin
            q = '1;
            r = a_i;
        end else if (ovf_i) begin
            q = op_is_w(op_i) ? {{(WIDTH-32){1'b1}}, SMIN32} : SMIN64[WIDTH-1:0];
            r = '0;
        end
        sel      = op_is_rem(op_i) ? r : q;
        result_o = op_is_w(op_i) ? {{(WIDTH-32){sel[31]}}, sel[31:0]} : sel;
    end

endmodule

// File: rtl/div_frontend.sv
// RV64M divide/remainder front-end around an unsigned multicycle core; DIV_FASTPATH_EN short-cuts /0 and overflow.
// Latency: WIDTH+4 cycles from accept via the core, 1 cycle on the fast path.
// Backpressure: in_ready low while busy; out_valid is a one-cycle pulse with no backpressure; flush kills in-flight work.
module div_frontend
    import pipes::*;
#(
    parameter int WIDTH = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2:0]         in_op,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic               flush,
    output logic               out_valid,
    output logic [WIDTH-1:0]   out_result,
    output logic               div_valid,
    output logic [WIDTH-1:0]   div_a,
    output logic [WIDTH-1:0]   div_b,
    input  logic               div_done,
    input  logic [2*WIDTH-1:0] div_c
);

    div_state_t       state_q;
    logic             in_ready_q, div_valid_q, out_valid_q;
    logic [2:0]       op_q;
    logic             neg_q_q, neg_r_q, dz_q;
    logic [WIDTH-1:0] a_q, mag_a_q, mag_b_q, result_q;

    logic             acc_w_d, acc_s_d, sa_d, sb_d, dz_d, accept;
    logic [WIDTH-1:0] a_ext_d, b_ext_d, mag_a_d, mag_b_d;

    logic [2:0]       fix_op;
    logic             fix_neg_q, fix_neg_r, fix_dz, fix_ovf;
    logic [WIDTH-1:0] fix_a, fix_result;

    // flush wins over any handshake or pulse in the same cycle
    assign accept     = in_valid & in_ready_q & ~flush;
    assign in_ready   = in_ready_q & ~flush;
    assign div_valid  = div_valid_q & ~flush;
    assign out_valid  = out_valid_q & ~flush;
    assign out_result = result_q;
    assign div_a      = mag_a_q;
    assign div_b      = mag_b_q;

    assign acc_w_d = op_is_w(in_op);
    assign acc_s_d = ~op_is_unsigned(in_op);
    assign a_ext_d = acc_w_d ? {{(WIDTH-32){in_a[31] & acc_s_d}}, in_a[31:0]} : in_a;
    assign b_ext_d = acc_w_d ? {{(WIDTH-32){in_b[31] & acc_s_d}}, in_b[31:0]} : in_b;
    assign sa_d    = acc_s_d & a_ext_d[WIDTH-1];
    assign sb_d    = acc_s_d & b_ext_d[WIDTH-1];
    assign mag_a_d = sa_d ? -a_ext_d : a_ext_d;
    assign mag_b_d = sb_d ? -b_ext_d : b_ext_d;
    assign dz_d    = (b_ext_d == '0);

`ifdef DIV_FASTPATH_EN
    logic ovf_d;
    logic sel_acc;

    assign ovf_d = acc_s_d & (b_ext_d == '1) &
                   (a_ext_d == (acc_w_d ? {{(WIDTH-32){1'b1}}, SMIN32} : SMIN64[WIDTH-1:0]));
    // In IDLE the fix-up sees the incoming request so special cases can answer in one cycle
    assign sel_acc   = (state_q == IDLE);
    assign fix_op    = sel_acc ? in_op : op_q;
    assign fix_neg_q = sel_acc ? (sa_d ^ sb_d) : neg_q_q;
    assign fix_neg_r = sel_acc ? sa_d : neg_r_q;
    assign fix_dz    = sel_acc ? dz_d : dz_q;
    assign fix_ovf   = sel_acc & ovf_d;
    assign fix_a     = sel_acc ? a_ext_d : a_q;
`else
    assign fix_op    = op_q;
    assign fix_neg_q = neg_q_q;
    assign fix_neg_r = neg_r_q;
    assign fix_dz    = dz_q;
    assign fix_ovf   = 1'b0;
    assign fix_a     = a_q;
`endif

    div_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
        .uq_i     (div_c[WIDTH-1:0]),
        .ur_i     (div_c[2*WIDTH-1:WIDTH]),
        .neg_q_i  (fix_neg_q),
        .neg_r_i  (fix_neg_r),
        .op_i     (fix_op),
        .dz_i     (fix_dz),
        .ovf_i    (fix_ovf),
        .a_i      (fix_a),
        .result_o (fix_result)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            div_valid_q <= 1'b0;
            out_valid_q <= 1'b0;
            op_q        <= '0;
            neg_q_q     <= 1'b0;
            neg_r_q     <= 1'b0;
            dz_q        <= 1'b0;
            a_q         <= '0;
            mag_a_q     <= '0;
            mag_b_q     <= '0;
            result_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        op_q       <= in_op;
                        neg_q_q    <= sa_d ^ sb_d;
                        neg_r_q    <= sa_d;
                        dz_q       <= dz_d;
                        a_q        <= a_ext_d;
                        mag_a_q    <= mag_a_d;
                        mag_b_q    <= mag_b_d;
                        in_ready_q <= 1'b0;
`ifdef DIV_FASTPATH_EN
                        if (dz_d | ovf_d) begin
                            result_q    <= fix_result;
                            out_valid_q <= 1'b1;
                            state_q     <= RESP;
                        end else begin
                            div_valid_q <= 1'b1;
                            state_q     <= ISSUE;
                        end
`else
                        div_valid_q <= 1'b1;
                        state_q     <= ISSUE;
`endif
                    end
                end
                ISSUE: begin
                    div_valid_q <= 1'b0;
                    if (flush) begin
                        in_ready_q <= 1'b1;
                        state_q    <= IDLE;
                    end else begin
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (flush) begin
                        state_q <= DRAIN;
                    end else if (div_done) begin
                        state_q <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (flush) begin
                        in_ready_q <= 1'b1;
                        state_q    <= IDLE;
                    end else begin
                        result_q    <= fix_result;
                        out_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end
                end
                RESP: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= IDLE;
                end
                DRAIN: begin
                    if (div_done) begin
                        in_ready_q <= 1'b1;
                        state_q    <= IDLE;
                    end
                end
                default: begin
                    div_valid_q <= 1'b0;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

endmodule
